// File: rtl/magic_packet_checker_pkg.sv
// Shared types and helpers for the magic-packet read-side checker.
package magic_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must hold 0..DEPTH inclusive.
  function automatic int cntwid(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/magic_packet_checker_if.sv
// FIFO port bundle observed by the magic-packet checker.
interface magic_packet_checker_if #(
  parameter int WIDTH = 8
);
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (
    output push, pop, full, empty, din, dout
  );

  modport slave (
    input push, pop, full, empty, din, dout
  );
endinterface

// File: rtl/magic_packet_checker_ff_en.sv
// Enable register with synchronous active-high reset to a fixed value.
module magic_packet_checker_ff_en #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/magic_packet_checker.sv
// Tracks one captured FIFO entry through the queue and checks it on exit.
module magic_packet_checker
  import magic_pkt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int CNTWID = cntwid(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  magic_packet_checker_if.slave  fifo,
  input  logic                   capture_req,
  output logic                   armed,
  output logic                   done,
  output logic [CNTWID-1:0]      cnt,
  output logic [WIDTH-1:0]       magic_data,
  output logic                   exiting,
  output logic                   data_ok,
  output logic                   error
);

  localparam logic [CNTWID-1:0] CNT_MAX = CNTWID'(DEPTH);

  logic        wr;
  logic        rd;
  logic        capture;
  logic        mismatch;
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        state_en;
  state_t      state;
  logic        cnt_en;
  logic [CNTWID-1:0] cnt_d;

  assign state = state_t'(state_q);

  assign wr       = fifo.push & ~fifo.full;
  assign rd       = fifo.pop & ~fifo.empty;
  assign capture  = (state == ST_IDLE) & capture_req & wr;
  assign exiting  = (state == ST_ARMED) & rd & (cnt == '0);
  assign mismatch = exiting & (fifo.dout != magic_data);
  assign data_ok  = ~mismatch;

  assign armed = (state == ST_ARMED);
  assign done  = (state == ST_DONE);

  always_comb begin
    state_en = capture | exiting;
    state_d  = capture ? ST_ARMED : ST_DONE;
  end

  always_comb begin
    cnt_en = 1'b0;
    cnt_d  = cnt;
    unique case (state)
      ST_IDLE: begin
        if (capture) begin
          // The captured entry itself is not ahead of itself; only the pop moves cnt.
          cnt_en = 1'b1;
          cnt_d  = (rd && cnt != '0) ? cnt - 1'b1 : cnt;
        end else if (wr && !rd) begin
          cnt_en = (cnt != CNT_MAX);
          cnt_d  = cnt + 1'b1;
        end else if (rd && !wr) begin
          cnt_en = (cnt != '0);
          cnt_d  = cnt - 1'b1;
        end
      end
      ST_ARMED: begin
        cnt_en = rd & (cnt != '0);
        cnt_d  = cnt - 1'b1;
      end
      default: begin
        cnt_en = 1'b0;
        cnt_d  = cnt;
      end
    endcase
  end

  magic_packet_checker_ff_en #(
    .W       (2),
    .RST_VAL (ST_IDLE)
  ) u_state (
    .clk (clk),
    .rst (rst),
    .en  (state_en),
    .d   (state_d),
    .q   (state_q)
  );

  magic_packet_checker_ff_en #(
    .W       (CNTWID),
    .RST_VAL ('0)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en | rst),
    .d   (cnt_d),
    .q   (cnt)
  );

  magic_packet_checker_ff_en #(
    .W       (WIDTH),
    .RST_VAL ('0)
  ) u_magic (
    .clk (clk),
    .rst (rst),
    .en  (capture | rst),
    .d   (fifo.din),
    .q   (magic_data)
  );

  magic_packet_checker_ff_en #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_error (
    .clk (clk),
    .rst (rst),
    .en  (mismatch),
    .d   (1'b1),
    .q   (error)
  );

endmodule

// File: tb/tb_magic_packet_checker.sv
// Directed bench for magic_packet_checker with hand-computed expectations.
module tb_magic_packet_checker;
  import magic_pkt_pkg::*;

  localparam int DEPTH  = 8;
  localparam int WIDTH  = 8;
  localparam int CNTWID = 4;

  logic clk = 1'b0;
  logic rst;
  logic capture_req;
  logic armed, done, exiting, data_ok, error;
  logic [CNTWID-1:0] cnt;
  logic [WIDTH-1:0]  magic_data;

  int errors = 0;
  int checks = 0;

  magic_packet_checker_if #(.WIDTH(WIDTH)) fif ();

  magic_packet_checker #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo        (fif.slave),
    .capture_req (capture_req),
    .armed       (armed),
    .done        (done),
    .cnt         (cnt),
    .magic_data  (magic_data),
    .exiting     (exiting),
    .data_ok     (data_ok),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic p, input logic po, input logic f, input logic e,
                       input logic cap, input logic [WIDTH-1:0] di,
                       input logic [WIDTH-1:0] dq, input logic r);
    fif.push    = p;
    fif.pop     = po;
    fif.full    = f;
    fif.empty   = e;
    capture_req = cap;
    fif.din     = di;
    fif.dout    = dq;
    rst         = r;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h00, 1);
    tick();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    #2;
    // Reset state
    drive(1, 1, 0, 0, 1, 8'hFF, 8'hFF, 1);
    tick();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h00, 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_magic", 32'(magic_data), 0);
    chk("rst_exiting", 32'(exiting), 0);
    chk("rst_data_ok", 32'(data_ok), 1);

    // 1: three pushes then one pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, (i == 0), 0, 8'(i), 8'h00, 0);
      tick();
    end
    chk("t1_cnt3", 32'(cnt), 3);
    chk("t1_armed", 32'(armed), 0);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    tick();
    chk("t1_cnt2", 32'(cnt), 2);

    // 2: capture 0xA5 behind two entries, exit with matching data
    drive(1, 0, 0, 0, 1, 8'hA5, 8'h00, 0);
    tick();
    chk("t2_armed", 32'(armed), 1);
    chk("t2_cnt", 32'(cnt), 2);
    chk("t2_magic", 32'(magic_data), 32'hA5);
    drive(1, 1, 0, 0, 1, 8'h77, 8'h11, 0);
    chk("t2_noexit1", 32'(exiting), 0);
    tick();
    chk("t2_cnt1", 32'(cnt), 1);
    chk("t2_magic_hold", 32'(magic_data), 32'hA5);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h22, 0);
    tick();
    chk("t2_cnt0", 32'(cnt), 0);
    chk("t2_inv", 32'(cnt < DEPTH), 1);
    drive(0, 1, 0, 0, 0, 8'h00, 8'hA5, 0);
    chk("t2_exiting", 32'(exiting), 1);
    chk("t2_data_ok", 32'(data_ok), 1);
    tick();
    chk("t2_done", 32'(done), 1);
    chk("t2_armed_off", 32'(armed), 0);
    chk("t2_error", 32'(error), 0);
    chk("t2_cnt_done", 32'(cnt), 0);
    drive(1, 1, 0, 0, 1, 8'h99, 8'h00, 0);
    chk("t2_done_noexit", 32'(exiting), 0);
    chk("t2_done_ok", 32'(data_ok), 1);
    tick();
    chk("t2_done_cnt", 32'(cnt), 0);
    chk("t2_done_magic", 32'(magic_data), 32'hA5);
    chk("t2_done_hold", 32'(done), 1);

    // 3: same flow, mismatching exit data
    do_reset();
    drive(1, 0, 0, 1, 0, 8'h01, 8'h00, 0);
    tick();
    drive(1, 0, 0, 0, 0, 8'h02, 8'h00, 0);
    tick();
    drive(1, 0, 0, 0, 1, 8'hA5, 8'h00, 0);
    tick();
    chk("t3_cnt", 32'(cnt), 2);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h11, 0);
    tick();
    drive(0, 1, 0, 0, 0, 8'h00, 8'h22, 0);
    tick();
    drive(0, 1, 0, 0, 0, 8'h00, 8'h5A, 0);
    chk("t3_exiting", 32'(exiting), 1);
    chk("t3_data_bad", 32'(data_ok), 0);
    chk("t3_err_not_yet", 32'(error), 0);
    tick();
    chk("t3_error", 32'(error), 1);
    chk("t3_done", 32'(done), 1);
    drive(0, 1, 0, 0, 0, 8'h00, 8'hA5, 0);
    tick();
    tick();
    chk("t3_error_sticky", 32'(error), 1);
    do_reset();
    chk("t3_error_clr", 32'(error), 0);
    chk("t3_done_clr", 32'(done), 0);

    // 4: capture and pop together at cnt=1
    drive(1, 0, 0, 1, 0, 8'h10, 8'h00, 0);
    tick();
    chk("t4_cnt1", 32'(cnt), 1);
    drive(1, 1, 0, 0, 1, 8'h3C, 8'h10, 0);
    chk("t4_noexit", 32'(exiting), 0);
    tick();
    chk("t4_cnt0", 32'(cnt), 0);
    chk("t4_armed", 32'(armed), 1);
    chk("t4_magic", 32'(magic_data), 32'h3C);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h3C, 0);
    chk("t4_exiting", 32'(exiting), 1);
    chk("t4_data_ok", 32'(data_ok), 1);

    // 5: saturation, push while full, pop while empty, wr+rd together
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0, 0, 8'(i), 8'h00, 0);
      tick();
    end
    chk("t5_sat", 32'(cnt), DEPTH);
    drive(1, 0, 1, 0, 1, 8'hEE, 8'h00, 0);
    tick();
    chk("t5_full_nocap", 32'(armed), 0);
    chk("t5_full_cnt", 32'(cnt), DEPTH);
    chk("t5_full_magic", 32'(magic_data), 0);
    drive(1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    tick();
    chk("t5_wr_rd", 32'(cnt), DEPTH);
    do_reset();
    drive(0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    tick();
    chk("t5_empty_pop", 32'(cnt), 0);
    drive(0, 0, 0, 1, 1, 8'h44, 8'h00, 0);
    tick();
    chk("t5_cap_no_wr", 32'(armed), 0);

    // 6: reset while armed, then fresh capture into empty FIFO
    drive(1, 0, 0, 1, 0, 8'h01, 8'h00, 0);
    tick();
    drive(1, 0, 0, 0, 0, 8'h02, 8'h00, 0);
    tick();
    drive(1, 0, 0, 0, 1, 8'h66, 8'h00, 0);
    tick();
    chk("t6_armed", 32'(armed), 1);
    chk("t6_cnt2", 32'(cnt), 2);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);
    tick();
    chk("t6_rst_cnt", 32'(cnt), 0);
    chk("t6_rst_armed", 32'(armed), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_error", 32'(error), 0);
    chk("t6_rst_magic", 32'(magic_data), 0);
    drive(1, 0, 0, 1, 1, 8'h77, 8'h00, 0);
    tick();
    chk("t6_recap", 32'(armed), 1);
    chk("t6_recap_cnt", 32'(cnt), 0);
    chk("t6_recap_magic", 32'(magic_data), 32'h77);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h77, 0);
    chk("t6_exit", 32'(exiting), 1);
    tick();
    chk("t6_done", 32'(done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/magic_packet_checker.md
Name: magic_packet_checker

Overview:
- Read-side companion to the magic-packet tracker for formal FIFO verification.
- Captures one nondeterministically chosen packet ("magic packet") on the write side and counts the entries queued ahead of it.
- Flags the pop on which the magic packet leaves the FIFO and checks the data popped against the captured value.
- Sits beside the FIFO under test; all inputs are driven by FIFO ports or free solver inputs, and the outputs feed assertions.

Parameters:
DEPTH, 8, FIFO capacity in entries
WIDTH, 8, FIFO data width in bits
CNTWID, $clog2(DEPTH)+1, width of the occupancy/position counter (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
push  input  1  FIFO write request
pop  input  1  FIFO read request
full  input  1  FIFO full flag; a push while full is dropped
empty  input  1  FIFO empty flag; a pop while empty is dropped
din  input  WIDTH  FIFO write data
dout  input  WIDTH  FIFO read data; show-ahead, valid in the same cycle as pop
capture_req  input  1  free solver input selecting the current push as the magic packet
armed  output  1  magic packet is inside the FIFO
done  output  1  magic packet has exited
cnt  output  CNTWID  IDLE: FIFO occupancy; ARMED: entries ahead of the magic packet
magic_data  output  WIDTH  captured magic packet value
exiting  output  1  combinational; this cycle pops the magic packet
data_ok  output  1  combinational; low only when exiting and dout != magic_data
error  output  1  sticky; set on the cycle after a data mismatch

Behaviour:
- Reset: rst has priority over all inputs. It forces state IDLE and sets cnt=0, magic_data=0, error=0. armed, done, exiting and data_ok go to 0, 0, 0 and 1 in the same cycle. A reset mid-operation discards any capture.
- Qualified events: wr = push & ~full; rd = pop & ~empty.
- State machine: IDLE -> ARMED -> DONE. DONE is exited only by rst.
- IDLE:
  - cnt += wr, then cnt -= rd; wr and rd together leave cnt unchanged.
  - cnt saturates at DEPTH and never wraps below 0.
  - If capture_req & wr:
    - magic_data <= din.
    - cnt <= cnt - rd, the entries ahead of the magic packet after this cycle's pop.
    - Next state is ARMED.
  - capture_req without wr is ignored.
- ARMED:
  - Pushes and capture_req are ignored.
  - rd & cnt!=0: cnt -= 1.
  - rd & cnt==0: exiting=1. Compare dout to magic_data; on mismatch data_ok=0 and error is set at the next edge. Next state is DONE, and cnt stays 0.
- DONE: cnt and magic_data hold, error holds, and all inputs are ignored.
- Only one capture per reset.
- Latency: armed/done/cnt/error are registered (1 cycle); exiting/data_ok are combinational.
- Simultaneous events:
  - Capture and pop in the same cycle: the pop removes an older entry. It is never the magic packet, because the FIFO is read-before-write.
  - Capture into an empty FIFO gives cnt=0, so the next rd is the exit.
- Invariant for bench assertions: in ARMED, cnt < DEPTH.
- Arithmetic: unsigned CNTWID-bit values, with a guard against wrap on both increment and decrement.

Decomposition:
- Shared package magic_pkt_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ARMED=2'd1, ST_DONE=2'd2;
  - the derived CNTWID helper.
- Sub-module: the team's existing FF enable-register. Instantiate it separately for:
  - state;
  - cnt (en = wr|rd|rst|capture);
  - magic_data (en = capture|rst);
  - error.

Test Plan:
1. Reset, then 3 pushes without capture -> cnt=3, armed=0; then 1 pop -> cnt=2.
2. cnt=2, push din=0xA5 with capture_req -> armed=1, cnt=2, magic_data=0xA5. Pops with dout=0x11, 0x22 -> cnt 1, 0. Third pop with dout=0xA5 -> exiting=1, data_ok=1; next cycle done=1, error=0.
3. Same as 2, but the third pop has dout=0x5A -> data_ok=0 that cycle; error=1 next cycle and stays 1 until rst.
4. cnt=1, capture push (din=0x3C) and pop in the same cycle -> cnt=0, armed=1. Next pop with dout=0x3C -> exiting=1.
5. full=1, push with capture_req -> no capture, armed=0, cnt=DEPTH (8). pop on empty in IDLE at cnt=0 -> cnt stays 0.
6. ARMED, cnt=2, rst=1 with pop=1 -> next cycle cnt=0, armed=0, done=0, error=0; a new capture is then accepted.
